// File: rtl/key_strobe_gen_pkg.sv
`default_nettype none
// ============================================================
// ttt_pkg: keypad sizing, cell indexing and arbiter state type
// Rev 1.0
// ============================================================
package ttt_pkg;

  localparam int NUM_KEYS  = 9;
  localparam int KEY_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } arb_state_t;

  // Cell xy maps to key bit 3*x + y; the display stage uses the same mapping.
  function automatic logic [KEY_IDX_W-1:0] cell_idx(input int x, input int y);
    return KEY_IDX_W'(3 * x + y);
  endfunction

  function automatic logic [KEY_IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_strobe_gen_if.sv
`default_nettype none
// ============================================================
// key_strobe_gen_if: keypad in, blanking in, press strobes out
// Rev 1.0
// ============================================================
interface key_strobe_gen_if;
  import ttt_pkg::*;

  logic [NUM_KEYS-1:0] key_n;
  logic                vnotactive;
  logic                board_but00;
  logic                board_but01;
  logic                board_but02;
  logic                board_but10;
  logic                board_but11;
  logic                board_but12;
  logic                board_but20;
  logic                board_but21;
  logic                board_but22;
  logic                press_pending;

  modport master (
    output key_n, vnotactive,
    input  board_but00, board_but01, board_but02,
           board_but10, board_but11, board_but12,
           board_but20, board_but21, board_but22,
           press_pending
  );

  modport slave (
    input  key_n, vnotactive,
    output board_but00, board_but01, board_but02,
           board_but10, board_but11, board_but12,
           board_but20, board_but21, board_but22,
           press_pending
  );

endinterface
`default_nettype wire

// File: rtl/key_strobe_gen_debounce.sv
`default_nettype none
// ============================================================
// key_debounce: sync, debounce and press-edge detect for one key
// Rev 1.0
// ============================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic key_n,
  output logic      stable,
  output logic      ev
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_ev;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= key_n;
      r_sync <= r_meta;
    end
  end

  // A single matching cycle restarts the count, so only a clean run flips.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else if (r_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_stable <= r_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stable_d <= 1'b1;
      r_ev       <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_ev       <= r_stable_d & ~r_stable;
    end
  end

  assign stable = r_stable;
  assign ev     = r_ev;

endmodule
`default_nettype wire

// File: rtl/key_strobe_gen.sv
`default_nettype none
// ============================================================
// key_strobe_gen: debounced keypad -> blanking-aligned strobes
// Rev 1.0
// ============================================================
module key_strobe_gen
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  key_strobe_gen_if.slave   bus
);

  logic [NUM_KEYS-1:0]  w_ev;
  // Debounced levels are not needed here; only press events feed the arbiter.
  logic [NUM_KEYS-1:0]  w_stable_unused;
  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [KEY_IDX_W-1:0] r_pend_idx;
  logic [NUM_KEYS-1:0]  w_strobe_n;
  logic [NUM_KEYS-1:0]  r_but;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .CLK    (CLK),
      .RST    (RST),
      .key_n  (bus.key_n[g]),
      .stable (w_stable_unused[g]),
      .ev     (w_ev[g])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_ev) w_state_nxt = PEND;
      PEND:    if (bus.vnotactive) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_strobe_n = '1;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (r_state == PEND && bus.vnotactive && r_pend_idx == KEY_IDX_W'(i)) begin
        w_strobe_n[i] = 1'b0;
      end
    end
  end

  // Events arriving while a press is pending are intentionally discarded.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pend_idx <= '0;
    end else if (r_state == IDLE && |w_ev) begin
      r_pend_idx <= lowest_idx(w_ev);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_but <= '1;
    end else begin
      r_but <= w_strobe_n;
    end
  end

  assign bus.press_pending = (r_state == PEND);
  assign bus.board_but00   = r_but[cell_idx(0, 0)];
  assign bus.board_but01   = r_but[cell_idx(0, 1)];
  assign bus.board_but02   = r_but[cell_idx(0, 2)];
  assign bus.board_but10   = r_but[cell_idx(1, 0)];
  assign bus.board_but11   = r_but[cell_idx(1, 1)];
  assign bus.board_but12   = r_but[cell_idx(1, 2)];
  assign bus.board_but20   = r_but[cell_idx(2, 0)];
  assign bus.board_but21   = r_but[cell_idx(2, 1)];
  assign bus.board_but22   = r_but[cell_idx(2, 2)];

endmodule
`default_nettype wire

// File: tb/tb_key_strobe_gen.sv
`default_nettype none
// ============================================================
// tb_key_strobe_gen: directed scenarios plus randomized model check
// Rev 1.0
// ============================================================
module tb_key_strobe_gen;

  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  key_strobe_gen_if bus();

  key_strobe_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] dut_but();
    return {bus.board_but22, bus.board_but21, bus.board_but20,
            bus.board_but12, bus.board_but11, bus.board_but10,
            bus.board_but02, bus.board_but01, bus.board_but00};
  endfunction

  // ---------------- reference model ----------------
  // A key's level flips once the last D synchronized samples all disagree with it.
  logic [8:0]          m_raw1, m_s, m_stable, m_fell, m_ev, m_but;
  logic [D-2:0][8:0]   m_hist;
  logic                m_pend;
  logic [3:0]          m_idx;

  function automatic logic [8:0] window_flip(input logic [8:0] s_now,
                                             input logic [D-2:0][8:0] s_old,
                                             input logic [8:0] st);
    logic [8:0] f;
    f = s_now ^ st;
    for (int j = 0; j < D - 1; j++) f = f & (s_old[j] ^ st);
    return f;
  endfunction

  function automatic logic [3:0] first_set(input logic [8:0] v);
    logic [3:0] r;
    logic       found;
    r = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (v[i] && !found) begin
        r = 4'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_raw1   <= '1;
      m_s      <= '1;
      m_hist   <= '1;
      m_stable <= '1;
      m_fell   <= '0;
      m_ev     <= '0;
      m_pend   <= 1'b0;
      m_idx    <= 4'd0;
      m_but    <= '1;
    end else begin
      m_raw1   <= bus.key_n;
      m_s      <= m_raw1;
      m_hist   <= {m_hist[D-3:0], m_s};
      m_stable <= m_stable ^ window_flip(m_s, m_hist, m_stable);
      m_fell   <= window_flip(m_s, m_hist, m_stable) & m_stable;
      m_ev     <= m_fell;
      m_but    <= (m_pend && bus.vnotactive) ? ~(9'd1 << m_idx) : 9'h1FF;
      if (m_pend) begin
        if (bus.vnotactive) m_pend <= 1'b0;
      end else if (m_ev != 9'd0) begin
        m_pend <= 1'b1;
        m_idx  <= first_set(m_ev);
      end
    end
  end

  // ---------------- helpers (no checking) ----------------
  task automatic settle(input int n);
    bus.key_n      = '1;
    bus.vnotactive = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b0;
    bus.key_n = '1;
    bus.vnotactive = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (dut_but() !== 9'h1FF) $display("FAIL reset_but got %b want %b", dut_but(), 9'h1FF);
    else n_pass++;
    n_checks++;
    if (bus.press_pending !== 1'b0) $display("FAIL reset_pend got %b want 0", bus.press_pending);
    else n_pass++;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (dut_but() !== 9'h1FF || bus.press_pending !== 1'b0)
      $display("FAIL post_reset got %b/%b want 111111111/0", dut_but(), bus.press_pending);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    logic [8:0] exp;
    bus.key_n[4] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      exp = (k == 9) ? ~(9'd1 << 4) : 9'h1FF;
      n_checks++;
      if (dut_but() !== exp) $display("FAIL clean_but k=%0d got %b want %b", k, dut_but(), exp);
      else n_pass++;
      n_checks++;
      if (bus.press_pending !== (k == 8)) $display("FAIL clean_pend k=%0d got %b want %b", k, bus.press_pending, (k == 8));
      else n_pass++;
    end
    bus.key_n[4] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      n_checks++;
      if (dut_but() !== 9'h1FF || bus.press_pending !== 1'b0)
        $display("FAIL clean_release k=%0d got %b/%b want 111111111/0", k, dut_but(), bus.press_pending);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [8:0] exp;
    for (int k = 1; k <= 16; k++) begin
      bus.key_n[0] = (k == 2);
      @(negedge CLK);
      exp = (k == 11) ? 9'h1FE : 9'h1FF;
      n_checks++;
      if (dut_but() !== exp) $display("FAIL bounce_but k=%0d got %b want %b", k, dut_but(), exp);
      else n_pass++;
      n_checks++;
      if (bus.press_pending !== (k == 10)) $display("FAIL bounce_pend k=%0d got %b want %b", k, bus.press_pending, (k == 10));
      else n_pass++;
    end
    settle(12);
    for (int k = 1; k <= 32; k++) begin
      bus.key_n[1] = ((k % 4) == 0);
      @(negedge CLK);
      n_checks++;
      if (dut_but() !== 9'h1FF || bus.press_pending !== 1'b0)
        $display("FAIL glitch k=%0d got %b/%b want 111111111/0", k, dut_but(), bus.press_pending);
      else n_pass++;
    end
    settle(12);
  endtask

  task automatic test_simultaneous();
    logic [8:0] exp;
    bus.key_n[2] = 1'b0;
    bus.key_n[7] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      exp = (k == 9) ? ~(9'd1 << 2) : 9'h1FF;
      n_checks++;
      if (dut_but() !== exp) $display("FAIL simul_but k=%0d got %b want %b", k, dut_but(), exp);
      else n_pass++;
    end
    settle(12);
  endtask

  task automatic test_blanking_hold();
    bus.vnotactive = 1'b0;
    bus.key_n[5]   = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      @(negedge CLK);
      n_checks++;
      if (dut_but() !== 9'h1FF) $display("FAIL hold_but k=%0d got %b want %b", k, dut_but(), 9'h1FF);
      else n_pass++;
      n_checks++;
      if (bus.press_pending !== (k >= 8)) $display("FAIL hold_pend k=%0d got %b want %b", k, bus.press_pending, (k >= 8));
      else n_pass++;
    end
    bus.vnotactive = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (dut_but() !== ~(9'd1 << 5) || bus.press_pending !== 1'b0)
      $display("FAIL hold_fire got %b/%b want %b/0", dut_but(), bus.press_pending, ~(9'd1 << 5));
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if (dut_but() !== 9'h1FF) $display("FAIL hold_after got %b want %b", dut_but(), 9'h1FF);
    else n_pass++;
    settle(12);
  endtask

  task automatic test_lockout();
    logic [8:0] exp;
    bus.vnotactive = 1'b0;
    bus.key_n[0]   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 9)  bus.key_n[3]   = 1'b0;
      if (k == 25) bus.vnotactive = 1'b1;
      @(negedge CLK);
      exp = (k == 25) ? 9'h1FE : 9'h1FF;
      n_checks++;
      if (dut_but() !== exp) $display("FAIL lock_but k=%0d got %b want %b", k, dut_but(), exp);
      else n_pass++;
      n_checks++;
      if (bus.press_pending !== (k >= 8 && k <= 24))
        $display("FAIL lock_pend k=%0d got %b want %b", k, bus.press_pending, (k >= 8 && k <= 24));
      else n_pass++;
    end
    bus.key_n[3] = 1'b1;
    repeat (12) @(negedge CLK);
    bus.key_n[3] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      exp = (k == 9) ? ~(9'd1 << 3) : 9'h1FF;
      n_checks++;
      if (dut_but() !== exp) $display("FAIL lock_repress k=%0d got %b want %b", k, dut_but(), exp);
      else n_pass++;
    end
    settle(12);
  endtask

  task automatic test_reset_mid_pending();
    logic [8:0] exp;
    bus.vnotactive = 1'b0;
    bus.key_n[6]   = 1'b0;
    repeat (8) @(negedge CLK);
    n_checks++;
    if (bus.press_pending !== 1'b1) $display("FAIL rstmid_pend got %b want 1", bus.press_pending);
    else n_pass++;
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (dut_but() !== 9'h1FF || bus.press_pending !== 1'b0)
      $display("FAIL rstmid_async got %b/%b want 111111111/0", dut_but(), bus.press_pending);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
    bus.vnotactive = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      exp = (k == 9) ? ~(9'd1 << 6) : 9'h1FF;
      n_checks++;
      if (dut_but() !== exp) $display("FAIL rstmid_held k=%0d got %b want %b", k, dut_but(), exp);
      else n_pass++;
    end
    settle(12);
    bus.vnotactive = 1'b0;
    bus.key_n[8]   = 1'b0;
    repeat (9) @(negedge CLK);
    #2 RST = 1'b0;
    bus.key_n = '1;
    @(negedge CLK);
    RST = 1'b1;
    bus.vnotactive = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      n_checks++;
      if (dut_but() !== 9'h1FF || bus.press_pending !== 1'b0)
        $display("FAIL rstmid_released k=%0d got %b/%b want 111111111/0", k, dut_but(), bus.press_pending);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    settle(12);
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      n_checks++;
      if (dut_but() !== m_but || bus.press_pending !== m_pend)
        $display("FAIL random c=%0d got %b/%b want %b/%b", c, dut_but(), bus.press_pending, m_but, m_pend);
      else n_pass++;
      for (int i = 0; i < 9; i++) begin
        if ($urandom_range(0, 15) == 0) bus.key_n[i] = ~bus.key_n[i];
      end
      bus.vnotactive = ($urandom_range(0, 2) != 0);
      if (c == 1500) begin
        #2 RST = 1'b0;
        #2 RST = 1'b1;
      end
    end
  endtask

  initial begin
    bus.key_n      = '1;
    bus.vnotactive = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_blanking_hold();
    test_lockout();
    test_reset_mid_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
